noc_link_repeater: RTL and testbench

- Credit-based retiming/buffering stage placed on a router-to-router link, directly downstream of a router output port and upstream of the neighbouring router input port.
- Accepts flits using the link protocol (data/dest/is_tail qualified by send; credit return) and stores them in a local FIFO.
- Forwards flits under its own downstream credit counter, so long inter-router wires can be split without changing router buffer depths.
- Returns one credit upstream per flit drained.

---
 rtl/noc_link_pkg.sv | 13 +
 rtl/noc_link_fifo.sv | 54 +++++
 rtl/noc_link_repeater.sv | 114 +++++++++++
 tb/tb_noc_link_repeater.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_link_pkg.sv
// noc_link_pkg: link defaults, FIFO word layout {is_tail, dest, data} and counter-width helpers.
package noc_link_pkg;
    localparam int LINK_FLIT_WIDTH = 64;
    localparam int LINK_DEST_WIDTH = 4;

    function automatic int link_word_width(input int flit_w, input int dest_w);
        return flit_w + dest_w + 1;
    endfunction

    function automatic int credit_cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/noc_link_fifo.sv
// noc_link_fifo: synchronous FIFO; a read frees the slot so a same-cycle write is accepted even when full.
module noc_link_fifo
    import noc_link_pkg::*;
#(
    parameter  int WIDTH = 69,
    parameter  int DEPTH = 4,
    localparam int CW    = credit_cnt_width(DEPTH),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_wr, do_rd;

    always_comb begin
        do_rd    = rd_en && !empty;
        do_wr    = wr_en && (!full || do_rd);
        wr_ptr_d = do_wr ? ((wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d = do_rd ? ((rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1)) : rd_ptr_q;
        count_d  = count_q + CW'(do_wr) - CW'(do_rd);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = count_q == CW'(DEPTH);
    assign empty   = count_q == '0;
    assign count   = count_q;
endmodule

// File: rtl/noc_link_repeater.sv
// noc_link_repeater: credit-based link retiming stage; buffers upstream flits and forwards them
// under its own downstream credit counter, returning one upstream credit per forwarded flit.
module noc_link_repeater
    import noc_link_pkg::*;
#(
    parameter  int FLIT_WIDTH         = LINK_FLIT_WIDTH,
    parameter  int DEST_WIDTH         = LINK_DEST_WIDTH,
    parameter  int BUFFER_DEPTH       = 4,
    parameter  int DOWNSTREAM_CREDITS = 1,
    parameter  bit INPUT_REG          = 1'b1,
    localparam int WW                 = link_word_width(FLIT_WIDTH, DEST_WIDTH),
    localparam int OW                 = $clog2(BUFFER_DEPTH + 1),
    localparam int CNTW               = credit_cnt_width(DOWNSTREAM_CREDITS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FLIT_WIDTH-1:0] data_in,
    input  logic [DEST_WIDTH-1:0] dest_in,
    input  logic                  is_tail_in,
    input  logic                  send_in,
    output logic                  credit_out,
    output logic [FLIT_WIDTH-1:0] data_out,
    output logic [DEST_WIDTH-1:0] dest_out,
    output logic                  is_tail_out,
    output logic                  send_out,
    input  logic                  credit_in,
    output logic [OW-1:0]         occupancy,
    output logic                  overflow_err,
    output logic                  credit_err
);
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(DOWNSTREAM_CREDITS);

    logic [WW-1:0]   in_word, fifo_rd_data, out_q, out_d;
    logic            in_vld, fifo_full, fifo_empty, pop, spurious;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            send_q, send_d, credit_q, credit_d;
    logic            ovf_q, ovf_d, cerr_q, cerr_d;

    generate
        if (INPUT_REG) begin : g_in_reg
            logic          in_vld_q, in_vld_d;
            logic [WW-1:0] in_word_q, in_word_d;
            always_comb begin
                in_vld_d  = send_in;
                in_word_d = {is_tail_in, dest_in, data_in};
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    in_vld_q  <= 1'b0;
                    in_word_q <= '0;
                end else begin
                    in_vld_q  <= in_vld_d;
                    in_word_q <= in_word_d;
                end
            end
            assign in_vld  = in_vld_q;
            assign in_word = in_word_q;
        end else begin : g_in_comb
            assign in_vld  = send_in;
            assign in_word = {is_tail_in, dest_in, data_in};
        end
    endgenerate

    noc_link_fifo #(
        .WIDTH (WW),
        .DEPTH (BUFFER_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (in_vld),
        .wr_data (in_word),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (occupancy)
    );

    // A credit arriving this cycle only reaches the counter next cycle, never enabling this pop.
    always_comb begin
        pop      = !fifo_empty && (cnt_q != '0);
        spurious = credit_in && !pop && (cnt_q == CNT_MAX);
        cnt_d    = spurious ? cnt_q : cnt_q - CNTW'(pop) + CNTW'(credit_in);
        send_d   = pop;
        credit_d = pop;
        out_d    = pop ? fifo_rd_data : out_q;
        ovf_d    = ovf_q || (in_vld && fifo_full && !pop);
        cerr_d   = cerr_q || spurious;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= CNT_MAX;
            send_q   <= 1'b0;
            credit_q <= 1'b0;
            out_q    <= '0;
            ovf_q    <= 1'b0;
            cerr_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            send_q   <= send_d;
            credit_q <= credit_d;
            out_q    <= out_d;
            ovf_q    <= ovf_d;
            cerr_q   <= cerr_d;
        end
    end

    assign {is_tail_out, dest_out, data_out} = out_q;
    assign send_out     = send_q;
    assign credit_out   = credit_q;
    assign overflow_err = ovf_q;
    assign credit_err   = cerr_q;
endmodule

// File: tb/tb_noc_link_repeater.sv
// tb_noc_link_repeater: directed checks of latency, credit flow, overflow, spurious credit, reset and throughput.
module tb_noc_link_repeater;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] a_data_in = '0, a_data_out, b_data_in = '0, b_data_out;
    logic [3:0]  a_dest_in = '0, a_dest_out, b_dest_in = '0, b_dest_out;
    logic        a_tail_in = 1'b0, a_tail_out, b_tail_in = 1'b0, b_tail_out;
    logic        a_send_in = 1'b0, a_send_out, b_send_in = 1'b0, b_send_out;
    logic        a_credit_in = 1'b0, a_credit_out, b_credit_in = 1'b0, b_credit_out;
    logic [2:0]  a_occ, b_occ;
    logic        a_ovf, a_cerr, b_ovf, b_cerr;

    noc_link_repeater #(.BUFFER_DEPTH(4), .DOWNSTREAM_CREDITS(1), .INPUT_REG(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .data_in(a_data_in), .dest_in(a_dest_in), .is_tail_in(a_tail_in),
        .send_in(a_send_in), .credit_out(a_credit_out), .data_out(a_data_out), .dest_out(a_dest_out),
        .is_tail_out(a_tail_out), .send_out(a_send_out), .credit_in(a_credit_in), .occupancy(a_occ),
        .overflow_err(a_ovf), .credit_err(a_cerr)
    );

    noc_link_repeater #(.BUFFER_DEPTH(4), .DOWNSTREAM_CREDITS(4), .INPUT_REG(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .data_in(b_data_in), .dest_in(b_dest_in), .is_tail_in(b_tail_in),
        .send_in(b_send_in), .credit_out(b_credit_out), .data_out(b_data_out), .dest_out(b_dest_out),
        .is_tail_out(b_tail_out), .send_out(b_send_out), .credit_in(b_credit_in), .occupancy(b_occ),
        .overflow_err(b_ovf), .credit_err(b_cerr)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [63:0] d, input logic [3:0] dst, input logic t);
        a_send_in = 1'b1;
        a_data_in = d;
        a_dest_in = dst;
        a_tail_in = t;
    endtask

    task automatic idle_a;
        a_send_in = 1'b0;
        a_data_in = '0;
        a_dest_in = '0;
        a_tail_in = 1'b0;
    endtask

    task automatic credit_a;
        a_credit_in = 1'b1;
        tick;
        a_credit_in = 1'b0;
    endtask

    initial begin
        int n, seen, nexp, order_err, bubbles, b_credits;
        logic [63:0] first;
        logic s1, s2;

        repeat (3) tick;
        rst_n = 1'b1;
        tick;
        chk("rst_send", a_send_out, 0);
        chk("rst_credit", a_credit_out, 0);
        chk("rst_data", a_data_out, 0);
        chk("rst_dest", a_dest_out, 0);
        chk("rst_tail", a_tail_out, 0);
        chk("rst_occ", a_occ, 0);
        chk("rst_ovf", a_ovf, 0);
        chk("rst_cerr", a_cerr, 0);

        // single flit: three-edge latency with the input register
        send_a(64'hDEAD, 4'h5, 1'b1);
        tick;
        idle_a;
        chk("t1_e1_occ", a_occ, 0);
        chk("t1_e1_send", a_send_out, 0);
        tick;
        chk("t1_e2_occ", a_occ, 1);
        chk("t1_e2_send", a_send_out, 0);
        tick;
        chk("t1_e3_send", a_send_out, 1);
        chk("t1_e3_data", a_data_out, 64'hDEAD);
        chk("t1_e3_dest", a_dest_out, 5);
        chk("t1_e3_tail", a_tail_out, 1);
        chk("t1_e3_credit", a_credit_out, 1);
        chk("t1_e3_occ", a_occ, 0);
        tick;
        chk("t1_e4_send", a_send_out, 0);
        chk("t1_e4_credit", a_credit_out, 0);
        chk("t1_e4_hold", a_data_out, 64'hDEAD);
        credit_a;

        // back-to-back stream with a single credit
        n = 0;
        first = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < 4) send_a(64'hA0 + 64'(i), 4'(i), i == 3);
            else idle_a;
            tick;
            if (a_send_out) begin
                n++;
                if (n == 1) first = a_data_out;
            end
        end
        chk("t2_count", 64'(n), 1);
        chk("t2_first", first, 64'hA0);
        chk("t2_occ", a_occ, 3);
        for (int k = 1; k < 4; k++) begin
            credit_a;
            chk("t2_wait", a_send_out, 0);
            tick;
            chk("t2_send", a_send_out, 1);
            chk("t2_data", a_data_out, 64'hA0 + 64'(k));
            chk("t2_tail", a_tail_out, k == 3);
        end
        chk("t2_drained", a_occ, 0);

        // overflow with no credits
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (i < 5) send_a(64'hB0 + 64'(i), 4'h2, 1'b0);
            else idle_a;
            tick;
            if (a_send_out) seen++;
        end
        chk("t4_no_send", 64'(seen), 0);
        chk("t4_occ", a_occ, 4);
        chk("t4_ovf", a_ovf, 1);
        for (int k = 0; k < 4; k++) begin
            credit_a;
            tick;
            chk("t4_send", a_send_out, 1);
            chk("t4_data", a_data_out, 64'hB0 + 64'(k));
        end
        credit_a;
        tick;
        chk("t4_no_fifth", a_send_out, 0);
        chk("t4_empty", a_occ, 0);

        // spurious credit while the counter is already full
        chk("t5_cerr_pre", a_cerr, 0);
        credit_a;
        chk("t5_cerr", a_cerr, 1);
        send_a(64'hC0, 4'h1, 1'b0);
        tick;
        idle_a;
        tick;
        tick;
        chk("t5_c0_send", a_send_out, 1);
        chk("t5_c0_data", a_data_out, 64'hC0);
        send_a(64'hC1, 4'h1, 1'b0);
        tick;
        idle_a;
        tick;
        tick;
        chk("t5_c1_held", a_send_out, 0);
        chk("t5_c1_occ", a_occ, 1);

        // reset with three flits buffered
        send_a(64'hC2, 4'h1, 1'b0);
        tick;
        send_a(64'hC3, 4'h1, 1'b0);
        tick;
        idle_a;
        tick;
        tick;
        chk("t6_occ_pre", a_occ, 3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_async_data", a_data_out, 0);
        chk("t6_async_occ", a_occ, 0);
        chk("t6_async_cerr", a_cerr, 0);
        chk("t6_async_ovf", a_ovf, 0);
        tick;
        tick;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (a_send_out || a_credit_out) seen++;
        end
        chk("t6_no_stale", 64'(seen), 0);
        chk("t6_occ", a_occ, 0);
        send_a(64'hD0, 4'h3, 1'b1);
        tick;
        idle_a;
        tick;
        tick;
        chk("t6_d0_send", a_send_out, 1);
        chk("t6_d0_data", a_data_out, 64'hD0);
        chk("t6_d0_credit", a_credit_out, 1);

        // sustained stream: four credits, downstream echoes each flit as a credit two cycles later
        nexp = 0;
        order_err = 0;
        bubbles = 0;
        b_credits = 0;
        s1 = 1'b0;
        s2 = 1'b0;
        for (int c = 0; c < 140; c++) begin
            b_send_in = c < 100;
            b_data_in = 64'(c);
            b_dest_in = 4'(c);
            b_tail_in = (c % 5) == 4;
            tick;
            b_credit_in = s2;
            s2 = s1;
            s1 = b_send_out;
            if (b_credit_out) b_credits++;
            if (b_send_out) begin
                if (b_data_out != 64'(nexp) || b_dest_out != 4'(nexp) || b_tail_out != ((nexp % 5) == 4))
                    order_err++;
                nexp++;
            end else if (nexp > 0 && nexp < 100) begin
                bubbles++;
            end
        end
        b_credit_in = 1'b0;
        chk("t3_count", 64'(nexp), 100);
        chk("t3_order", 64'(order_err), 0);
        chk("t3_bubbles", 64'(bubbles), 0);
        chk("t3_credits", 64'(b_credits), 100);
        chk("t3_occ", b_occ, 0);
        chk("t3_ovf", b_ovf, 0);
        chk("t3_cerr", b_cerr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
